// File: rtl/distributor_pkg.sv
// Shared bridge definitions: packet word width, byte-channel code encodings
// (identical to the byte-to-word packer) and the serializer's internal types.
package distributor_pkg;

  localparam int PFW_SZ = 64;

  localparam logic [1:0] PCC_DATA   = 2'd0;
  localparam logic [1:0] PCC_SOP    = 2'd1;
  localparam logic [1:0] PCC_EOP    = 2'd2;
  localparam logic [1:0] PCC_BADEOP = 2'd3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  // One captured packet word: payload, framing and index of its final byte.
  typedef struct packed {
    logic [PFW_SZ-1:0] data;
    logic              sop;
    logic [1:0]        code;
    logic [2:0]        last;
  } pword_t;

  // Mid-packet words always carry 8 bytes; last words carry bcnt+1.
  function automatic logic [2:0] last_index(input logic [1:0] code, input logic [2:0] bcnt);
    return (code == PCC_DATA) ? 3'd7 : bcnt;
  endfunction

endpackage

// File: rtl/distributor_if.sv
// Packet-word ingress (p_*) and byte egress (c_*) bundle for the distributor.
// Every channel is valid/ready: a transfer happens on the clock edge where
// srdy & drdy are both high, and the srdy side holds its payload until then.
interface distributor_if;
  import distributor_pkg::*;

  logic              p_srdy;
  logic              p_drdy;
  logic [PFW_SZ-1:0] p_data;
  logic              p_sop;
  logic [1:0]        p_code;
  logic [2:0]        p_bcnt;

  logic              c_srdy;
  logic              c_drdy;
  logic [7:0]        c_data;
  logic [1:0]        c_code;

  logic              err_framing;

  modport master (
    output p_srdy, p_data, p_sop, p_code, p_bcnt, c_drdy,
    input  p_drdy, c_srdy, c_data, c_code, err_framing
  );

  modport slave (
    input  p_srdy, p_data, p_sop, p_code, p_bcnt, c_drdy,
    output p_drdy, c_srdy, c_data, c_code, err_framing
  );

endinterface

// File: rtl/distributor_input.sv
// Input register slice for the packet word: captures the word on a kept
// handshake so the serializer only ever works from registered state.
module distributor_input
  import distributor_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   p_srdy,
  output logic   p_drdy,
  input  pword_t p_word,
  input  logic   room,
  input  logic   keep,
  output logic   load,
  output pword_t word_q
);

  assign p_drdy = room;
  // A handshake always completes; keep=0 swallows the word without capture.
  assign load   = p_srdy & room & keep;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q <= '0;
    end else if (load) begin
      word_q <= p_word;
    end
  end

endmodule

// File: rtl/distributor.sv
// Serializes 64-bit packet words into the 8-bit + code byte channel, MSB first.
// Define DISTRIBUTOR_FRAMING_CHK_EN to drop orphan words and flag err_framing.
module distributor
  import distributor_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  distributor_if.slave  bus,
  output state_t        dbg_state
);

  state_t     state;
  state_t     state_nxt;
  logic [2:0] idx;
  pword_t     p_word;
  pword_t     word_q;
  logic       busy;
  logic       at_last;
  logic       room;
  logic       keep;
  logic       load;
  logic       p_xfer;
  logic       c_xfer;
  logic [5:0] bit_lo;

  assign busy    = (state == S_SEND);
  assign at_last = (idx == word_q.last);
  // Ready again during the final byte handshake, so words stream back to back.
  assign room    = ~busy | (bus.c_drdy & at_last);
  assign p_xfer  = bus.p_srdy & room;
  assign c_xfer  = busy & bus.c_drdy;
  assign p_word  = {bus.p_data, bus.p_sop, bus.p_code, last_index(bus.p_code, bus.p_bcnt)};

  distributor_input u_input (
    .clk    (clk),
    .reset  (reset),
    .p_srdy (bus.p_srdy),
    .p_drdy (bus.p_drdy),
    .p_word (p_word),
    .room   (room),
    .keep   (keep),
    .load   (load),
    .word_q (word_q)
  );

`ifdef DISTRIBUTOR_FRAMING_CHK_EN
  logic in_pkt;
  logic err_q;

  // A word without sop outside a packet is an orphan and is never captured.
  assign keep = bus.p_sop | in_pkt;

  always_ff @(posedge clk) begin
    if (reset) begin
      in_pkt <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= p_xfer & ((~bus.p_sop & ~in_pkt) | (bus.p_sop & in_pkt));
      if (load) begin
        if (bus.p_code != PCC_DATA) begin
          in_pkt <= 1'b0;
        end else if (bus.p_sop) begin
          in_pkt <= 1'b1;
        end
      end
    end
  end

  assign bus.err_framing = err_q;
`else
  assign keep            = 1'b1;
  assign bus.err_framing = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      if (load) begin
        idx <= 3'd0;
      end else if (c_xfer && !at_last) begin
        idx <= idx + 3'd1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (load) state_nxt = S_SEND;
      end
      S_SEND: begin
        if (load) begin
          state_nxt = S_SEND;
        end else if (c_xfer && at_last) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bit_lo     = {3'd7 - idx, 3'b000};
    bus.c_srdy = busy;
    bus.c_data = word_q.data[bit_lo +: 8];
    // End-of-packet marking outranks SOP on a one-byte packet.
    if (at_last && (word_q.code != PCC_DATA)) begin
      bus.c_code = word_q.code;
    end else if ((idx == 3'd0) && word_q.sop) begin
      bus.c_code = PCC_SOP;
    end else begin
      bus.c_code = PCC_DATA;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_distributor.sv
// Bench for distributor: directed scenarios plus randomized packets checked by
// a byte-level scoreboard fed from a packet-rule reference model.
module tb_distributor;
  import distributor_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     n_cmp = 0;
  int     n_err = 0;
  bit     rnd_done = 1'b0;
  logic   err_pend = 1'b0;
  logic [9:0] exp_q[$];
`ifdef DISTRIBUTOR_FRAMING_CHK_EN
  logic   in_pkt_m = 1'b0;
`endif

  distributor_if bus();

  distributor dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int nbytes(input logic [1:0] code, input logic [2:0] bcnt);
    return (code == PCC_DATA) ? 8 : int'(bcnt) + 1;
  endfunction

  function automatic logic [9:0] byte_of(input logic [63:0] d, input logic sop,
                                         input logic [1:0] code, input logic [2:0] bcnt, input int i);
    logic [7:0] b;
    logic [1:0] cc;
    b = 8'(d >> (8 * (7 - i)));
    if (code != PCC_DATA && i == nbytes(code, bcnt) - 1) cc = code;
    else if (i == 0 && sop)                              cc = PCC_SOP;
    else                                                 cc = PCC_DATA;
    return {cc, b};
  endfunction

  function automatic void model_accept(input logic [63:0] d, input logic sop,
                                       input logic [1:0] code, input logic [2:0] bcnt);
    bit orphan;
    orphan = 1'b0;
`ifdef DISTRIBUTOR_FRAMING_CHK_EN
    orphan   = !sop && !in_pkt_m;
    err_pend = orphan || (sop && in_pkt_m);
    if (!orphan) begin
      if (code != PCC_DATA) in_pkt_m = 1'b0;
      else if (sop)         in_pkt_m = 1'b1;
    end
`endif
    if (!orphan) begin
      for (int i = 0; i < nbytes(code, bcnt); i++) exp_q.push_back(byte_of(d, sop, code, bcnt, i));
    end
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [9:0] e;
    #2;
    if (reset) begin
      exp_q.delete();
      err_pend = 1'b0;
`ifdef DISTRIBUTOR_FRAMING_CHK_EN
      in_pkt_m = 1'b0;
`endif
    end else begin
      n_cmp++;
      if (bus.err_framing !== err_pend) begin
        n_err++;
        $display("FAIL sb_err_framing: got %b required %b at %0t", bus.err_framing, err_pend, $time);
      end
      err_pend = 1'b0;
      if (bus.c_srdy === 1'b1 && bus.c_drdy === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL sb_extra_byte: got code=%0d data=%h required no byte at %0t",
                   bus.c_code, bus.c_data, $time);
        end else begin
          e = exp_q.pop_front();
          if ({bus.c_code, bus.c_data} !== e) begin
            n_err++;
            $display("FAIL sb_byte: got code=%0d data=%h required code=%0d data=%h at %0t",
                     bus.c_code, bus.c_data, e[9:8], e[7:0], $time);
          end
        end
      end
      if (bus.p_srdy === 1'b1 && bus.p_drdy === 1'b1)
        model_accept(bus.p_data, bus.p_sop, bus.p_code, bus.p_bcnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [63:0] d, input logic sop, input logic [1:0] code, input logic [2:0] bcnt);
    int t;
    t = 0;
    @(negedge clk);
    bus.p_srdy = 1'b1;
    bus.p_data = d;
    bus.p_sop  = sop;
    bus.p_code = code;
    bus.p_bcnt = bcnt;
    #1;
    while (bus.p_drdy !== 1'b1 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    n_cmp++;
    if (bus.p_drdy !== 1'b1) begin
      n_err++;
      $display("FAIL offer_timeout: p_drdy=%b required 1 within 100 cycles", bus.p_drdy);
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    bus.p_srdy = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp += 6;
    if (bus.c_srdy !== 1'b0)      begin n_err++; $display("FAIL rst_c_srdy: got %b required 0", bus.c_srdy); end
    if (bus.p_drdy !== 1'b1)      begin n_err++; $display("FAIL rst_p_drdy: got %b required 1", bus.p_drdy); end
    if (bus.c_code !== PCC_DATA)  begin n_err++; $display("FAIL rst_c_code: got %0d required %0d", bus.c_code, PCC_DATA); end
    if (bus.c_data !== 8'h00)     begin n_err++; $display("FAIL rst_c_data: got %h required 00", bus.c_data); end
    if (bus.err_framing !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b required 0", bus.err_framing); end
    if (dbg_state !== S_IDLE)     begin n_err++; $display("FAIL rst_state: got %0d required %0d", dbg_state, S_IDLE); end
  endtask

  task automatic test_single();
    logic [9:0] e;
    bus.c_drdy = 1'b1;
    offer(64'h0011_2233_4455_6677, 1'b1, PCC_EOP, 3'd7);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.p_srdy = 1'b0;
      #1;
      e = {(i == 0) ? PCC_SOP : ((i == 7) ? PCC_EOP : PCC_DATA), 8'(i * 8'h11)};
      n_cmp++;
      if ({bus.c_srdy, bus.c_code, bus.c_data} !== {1'b1, e}) begin
        n_err++;
        $display("FAIL single_byte%0d: got srdy=%b code=%0d data=%h required srdy=1 code=%0d data=%h",
                 i, bus.c_srdy, bus.c_code, bus.c_data, e[9:8], e[7:0]);
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL single_idle: c_srdy=%b required 0", bus.c_srdy); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] wd [3];
    logic [1:0]  wc [3];
    logic [2:0]  wb [3];
    logic [1:0]  ec;
    logic [7:0]  eb;
    logic        ed;
    int          wi;
    int          k;
    for (int w = 0; w < 3; w++) wd[w] = {$urandom(), $urandom()};
    wc[0] = PCC_DATA; wb[0] = 3'($urandom_range(0, 7));
    wc[1] = PCC_DATA; wb[1] = 3'($urandom_range(0, 7));
    wc[2] = PCC_EOP;  wb[2] = 3'd2;
    bus.c_drdy = 1'b1;
    wi = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (wi < 3) begin
        bus.p_srdy = 1'b1;
        bus.p_data = wd[wi];
        bus.p_sop  = (wi == 0);
        bus.p_code = wc[wi];
        bus.p_bcnt = wb[wi];
      end else begin
        bus.p_srdy = 1'b0;
      end
      #1;
      ed = (cyc == 0 || cyc == 8 || cyc == 16 || cyc >= 19);
      n_cmp++;
      if (bus.p_drdy !== ed) begin
        n_err++;
        $display("FAIL b2b_p_drdy cyc%0d: got %b required %b", cyc, bus.p_drdy, ed);
      end
      n_cmp++;
      if (cyc >= 1 && cyc <= 19) begin
        k  = cyc - 1;
        eb = 8'(wd[k / 8] >> (8 * (7 - (k % 8))));
        ec = (k == 0) ? PCC_SOP : ((k == 18) ? PCC_EOP : PCC_DATA);
        if ({bus.c_srdy, bus.c_code, bus.c_data} !== {1'b1, ec, eb}) begin
          n_err++;
          $display("FAIL b2b_byte%0d: got srdy=%b code=%0d data=%h required srdy=1 code=%0d data=%h",
                   k, bus.c_srdy, bus.c_code, bus.c_data, ec, eb);
        end
      end else if (bus.c_srdy !== 1'b0) begin
        n_err++;
        $display("FAIL b2b_idle cyc%0d: c_srdy=%b required 0", cyc, bus.c_srdy);
      end
      if (bus.p_srdy && bus.p_drdy) wi++;
    end
  endtask

  task automatic test_one_byte();
    logic [63:0] a;
    logic [63:0] b;
    a = {$urandom(), $urandom()};
    a[63:56] = 8'hAB;
    b = {$urandom(), $urandom()};
    bus.c_drdy = 1'b1;
    offer(a, 1'b1, PCC_BADEOP, 3'd0);
    @(negedge clk);
    bus.p_srdy = 1'b1;
    bus.p_data = b;
    bus.p_sop  = 1'b1;
    bus.p_code = PCC_EOP;
    bus.p_bcnt = 3'd7;
    #1;
    n_cmp++;
    if ({bus.c_srdy, bus.c_code, bus.c_data, bus.p_drdy} !== {1'b1, PCC_BADEOP, 8'hAB, 1'b1}) begin
      n_err++;
      $display("FAIL one_byte: got srdy=%b code=%0d data=%h p_drdy=%b required srdy=1 code=%0d data=ab p_drdy=1",
               bus.c_srdy, bus.c_code, bus.c_data, bus.p_drdy, PCC_BADEOP);
    end
    @(negedge clk);
    bus.p_srdy = 1'b0;
    #1;
    n_cmp++;
    if ({bus.c_srdy, bus.c_code, bus.c_data} !== {1'b1, PCC_SOP, b[63:56]}) begin
      n_err++;
      $display("FAIL one_byte_next: got srdy=%b code=%0d data=%h required srdy=1 code=%0d data=%h",
               bus.c_srdy, bus.c_code, bus.c_data, PCC_SOP, b[63:56]);
    end
    repeat (8) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL one_byte_drain: c_srdy=%b required 0", bus.c_srdy); end
  endtask

  task automatic test_backpressure();
    logic [63:0] d;
    logic [1:0]  ec;
    logic [7:0]  eb;
    logic        ed;
    int          k;
    d = {$urandom(), $urandom()};
    bus.c_drdy = 1'b1;
    offer(d, 1'b1, PCC_EOP, 3'd7);
    k = 0;
    for (int cyc = 0; cyc < 40 && k < 8; cyc++) begin
      @(negedge clk);
      bus.p_srdy = 1'b0;
      bus.c_drdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      #1;
      eb = 8'(d >> (8 * (7 - k)));
      ec = (k == 0) ? PCC_SOP : ((k == 7) ? PCC_EOP : PCC_DATA);
      ed = (k == 7) && bus.c_drdy;
      n_cmp += 2;
      if ({bus.c_srdy, bus.c_code, bus.c_data} !== {1'b1, ec, eb}) begin
        n_err++;
        $display("FAIL bp_byte%0d cyc%0d: got srdy=%b code=%0d data=%h required srdy=1 code=%0d data=%h",
                 k, cyc, bus.c_srdy, bus.c_code, bus.c_data, ec, eb);
      end
      if (bus.p_drdy !== ed) begin
        n_err++;
        $display("FAIL bp_p_drdy cyc%0d: got %b required %b", cyc, bus.p_drdy, ed);
      end
      if (bus.c_drdy) k++;
    end
    n_cmp++;
    if (k != 8) begin n_err++; $display("FAIL bp_count: got %0d bytes required 8", k); end
    bus.c_drdy = 1'b1;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL bp_idle: c_srdy=%b required 0", bus.c_srdy); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] d;
    logic [63:0] d2;
    d  = {$urandom(), $urandom()};
    d2 = {$urandom(), $urandom()};
    bus.c_drdy = 1'b1;
    offer(d, 1'b1, PCC_DATA, 3'd0);
    @(negedge clk);
    bus.p_srdy = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_data !== d[39:32]) begin n_err++; $display("FAIL rmid_byte3: got %h required %h", bus.c_data, d[39:32]); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp += 2;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL rmid_c_srdy: got %b required 0", bus.c_srdy); end
    if (bus.p_drdy !== 1'b1) begin n_err++; $display("FAIL rmid_p_drdy: got %b required 1", bus.p_drdy); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL rmid_stay_idle: c_srdy=%b required 0", bus.c_srdy); end
    offer(d2, 1'b1, PCC_EOP, 3'd3);
    @(negedge clk);
    bus.p_srdy = 1'b0;
    #1;
    n_cmp++;
    if ({bus.c_srdy, bus.c_code, bus.c_data} !== {1'b1, PCC_SOP, d2[63:56]}) begin
      n_err++;
      $display("FAIL rmid_fresh: got srdy=%b code=%0d data=%h required srdy=1 code=%0d data=%h",
               bus.c_srdy, bus.c_code, bus.c_data, PCC_SOP, d2[63:56]);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_framing();
    logic [63:0] d;
    d = {$urandom(), $urandom()};
    do_reset();
    bus.c_drdy = 1'b1;
    offer(d, 1'b0, PCC_DATA, 3'd3);
`ifdef DISTRIBUTOR_FRAMING_CHK_EN
    @(negedge clk);
    bus.p_srdy = 1'b0;
    #1;
    n_cmp++;
    if ({bus.c_srdy, bus.err_framing} !== 2'b01) begin
      n_err++;
      $display("FAIL orphan_flag: got srdy=%b err=%b required srdy=0 err=1", bus.c_srdy, bus.err_framing);
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if ({bus.c_srdy, bus.err_framing} !== 2'b00) begin
      n_err++;
      $display("FAIL orphan_pulse: got srdy=%b err=%b required srdy=0 err=0", bus.c_srdy, bus.err_framing);
    end
`else
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      bus.p_srdy = 1'b0;
      #1;
      n_cmp++;
      if ({bus.c_srdy, bus.c_code, bus.c_data, bus.err_framing} !== {1'b1, PCC_DATA, 8'(d >> (8 * (7 - i))), 1'b0}) begin
        n_err++;
        $display("FAIL orphan_pass%0d: got srdy=%b code=%0d data=%h err=%b required srdy=1 code=%0d data=%h err=0",
                 i, bus.c_srdy, bus.c_code, bus.c_data, bus.err_framing, PCC_DATA, 8'(d >> (8 * (7 - i))));
      end
    end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL orphan_idle: c_srdy=%b required 0", bus.c_srdy); end
`endif
    // Nested sop: second word restarts a packet while one is open.
    offer({$urandom(), $urandom()}, 1'b1, PCC_DATA, 3'd0);
    offer({$urandom(), $urandom()}, 1'b1, PCC_EOP, 3'd4);
    @(negedge clk);
    bus.p_srdy = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_random();
    int nw;
    int t;
    logic [1:0] code;
    rnd_done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          nw = $urandom_range(1, 4);
          for (int w = 0; w < nw; w++) begin
            if (w == nw - 1) code = ($urandom_range(0, 1) != 0) ? PCC_EOP : PCC_BADEOP;
            else             code = PCC_DATA;
            offer({$urandom(), $urandom()}, (w == 0), code, 3'($urandom_range(0, 7)));
          end
          if ($urandom_range(0, 3) == 0) begin
            @(negedge clk);
            bus.p_srdy = 1'b0;
          end
        end
        @(negedge clk);
        bus.p_srdy = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(negedge clk);
          bus.c_drdy = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.c_drdy = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(negedge clk);
      #3;
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL rnd_drain: %0d bytes outstanding required 0", exp_q.size()); end
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus.c_srdy !== 1'b0) begin n_err++; $display("FAIL rnd_idle: c_srdy=%b required 0", bus.c_srdy); end
  endtask

  initial begin
    bus.p_srdy = 1'b0;
    bus.p_data = '0;
    bus.p_sop  = 1'b0;
    bus.p_code = PCC_DATA;
    bus.p_bcnt = 3'd0;
    bus.c_drdy = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_one_byte();
    test_backpressure();
    test_reset_mid();
    test_framing();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
